// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard/stall controller.
package hazard_pkg;

    localparam int unsigned UNIT_LSU          = 0;
    localparam int unsigned UNIT_MUL          = 1;
    localparam int unsigned DEFAULT_NUM_UNITS = 2;

    // Bit i set makes unit i blocking; wider than any practical unit count.
    localparam logic [31:0] DEFAULT_BLOCKING_MASK = 32'h0000_0001;

    typedef enum logic {
        UNIT_IDLE = 1'b0,
        UNIT_BUSY = 1'b1
    } unit_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline status in, stall/flush/forward controls out.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_UNITS = 2,
    parameter int unsigned REG_AW    = 5
);
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    logic                 exe_valid;
    logic [REG_AW-1:0]    exe_rs1_addr;
    logic [REG_AW-1:0]    exe_rs2_addr;
    logic [REG_AW-1:0]    exe_rd_addr;
    logic                 exe_use_rs1;
    logic                 exe_use_rs2;
    logic                 exe_rd_wr;
    logic [NUM_UNITS-1:0] exe_unit_req;
    logic                 exe_new_pc_req;
    logic [NUM_UNITS-1:0] unit_ack;
    logic [REG_AW-1:0]    lsu_rd_addr;
    logic                 lsu_rd_wr;
    logic                 lsu_late;
    logic [REG_AW-1:0]    wrb_rd_addr;
    logic                 wrb_rd_wr;
    logic                 wrb_sb_clr;
    logic                 csr_new_pc_req;
    logic                 csr_wfi_req;

    logic                 fwd_lsu_rs1;
    logic                 fwd_lsu_rs2;
    logic                 fwd_wrb_rs1;
    logic                 fwd_wrb_rs2;
    logic                 pipe_stall;
    logic                 exe2lsu_stall;
    logic                 if2id_flush;
    logic                 id2exe_flush;
    logic                 exe2lsu_flush;
    logic                 lsu_flush;
    logic                 exe_new_pc_out;
    logic                 csr_new_pc_out;
    logic [NUM_UNITS-1:0] unit_busy;
    logic [NUM_REGS-1:0]  sb_busy;
    logic                 stall_timeout;

    // Pipeline side: drives status, consumes controls.
    modport master (
        output exe_valid, exe_rs1_addr, exe_rs2_addr, exe_rd_addr,
               exe_use_rs1, exe_use_rs2, exe_rd_wr, exe_unit_req, exe_new_pc_req,
               unit_ack, lsu_rd_addr, lsu_rd_wr, lsu_late,
               wrb_rd_addr, wrb_rd_wr, wrb_sb_clr, csr_new_pc_req, csr_wfi_req,
        input  fwd_lsu_rs1, fwd_lsu_rs2, fwd_wrb_rs1, fwd_wrb_rs2,
               pipe_stall, exe2lsu_stall, if2id_flush, id2exe_flush,
               exe2lsu_flush, lsu_flush, exe_new_pc_out, csr_new_pc_out,
               unit_busy, sb_busy, stall_timeout
    );

    // Controller side.
    modport slave (
        input  exe_valid, exe_rs1_addr, exe_rs2_addr, exe_rd_addr,
               exe_use_rs1, exe_use_rs2, exe_rd_wr, exe_unit_req, exe_new_pc_req,
               unit_ack, lsu_rd_addr, lsu_rd_wr, lsu_late,
               wrb_rd_addr, wrb_rd_wr, wrb_sb_clr, csr_new_pc_req, csr_wfi_req,
        output fwd_lsu_rs1, fwd_lsu_rs2, fwd_wrb_rs1, fwd_wrb_rs2,
               pipe_stall, exe2lsu_stall, if2id_flush, id2exe_flush,
               exe2lsu_flush, lsu_flush, exe_new_pc_out, csr_new_pc_out,
               unit_busy, sb_busy, stall_timeout
    );

endinterface

// File: rtl/mc_unit_tracker.sv
// Tracks whether one multi-cycle unit has work in flight.
module mc_unit_tracker
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic acc_i,
    input  logic ack_i,
    input  logic flush_i,
    output logic busy_o
);

    unit_state_e state_q, state_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= UNIT_IDLE;
        else        state_q <= state_d;
    end

    // Start on an accepted request unless it completes immediately; flush squashes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UNIT_IDLE: if (acc_i && !ack_i) state_d = UNIT_BUSY;
            UNIT_BUSY: if (ack_i)           state_d = UNIT_IDLE;
        endcase
        if (flush_i) state_d = UNIT_IDLE;
    end

    assign busy_o = (state_q == UNIT_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding, hazard detection and stall/flush control beside the pipeline registers.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned          NUM_UNITS     = DEFAULT_NUM_UNITS,
    parameter logic [NUM_UNITS-1:0] BLOCKING_MASK = NUM_UNITS'(DEFAULT_BLOCKING_MASK),
    parameter int unsigned          REG_AW        = 5,
    parameter int unsigned          WDOG_W        = 8
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave hz
);

    localparam int unsigned NUM_REGS = 1 << REG_AW;

    logic lsu_hit_rs1, lsu_hit_rs2, wrb_hit_rs1, wrb_hit_rs2;
    logic ld_use_raw, ld_use, sb_hazard, struct_hazard;
    logic busy_stall, pre_stall, blk_stall, pipe_stall;
    logic flush_lsu, redirect, front_flush;
    logic [NUM_UNITS-1:0] unit_busy, acc_blk, acc_nb, acc;
    logic [NUM_REGS-1:0]  sb_q, sb_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;

    // Operand matches against the LSU and WRB destinations; x0 never matches.
    assign lsu_hit_rs1 = (hz.exe_rs1_addr != '0) & (hz.exe_rs1_addr == hz.lsu_rd_addr) & hz.lsu_rd_wr;
    assign lsu_hit_rs2 = (hz.exe_rs2_addr != '0) & (hz.exe_rs2_addr == hz.lsu_rd_addr) & hz.lsu_rd_wr;
    assign wrb_hit_rs1 = (hz.exe_rs1_addr != '0) & (hz.exe_rs1_addr == hz.wrb_rd_addr) & hz.wrb_rd_wr;
    assign wrb_hit_rs2 = (hz.exe_rs2_addr != '0) & (hz.exe_rs2_addr == hz.wrb_rd_addr) & hz.wrb_rd_wr;

    assign ld_use_raw = hz.exe_valid & hz.lsu_late &
                        ((lsu_hit_rs1 & hz.exe_use_rs1) | (lsu_hit_rs2 & hz.exe_use_rs2));

    assign sb_hazard = hz.exe_valid & ((hz.exe_use_rs1 & sb_q[hz.exe_rs1_addr]) |
                                       (hz.exe_use_rs2 & sb_q[hz.exe_rs2_addr]) |
                                       (hz.exe_rd_wr   & sb_q[hz.exe_rd_addr]));

    assign struct_hazard = hz.exe_valid & (|(hz.exe_unit_req & unit_busy & ~BLOCKING_MASK));
    assign flush_lsu     = hz.csr_new_pc_req | hz.csr_wfi_req;

    // A blocking request stalls the very instruction that issues it, so its
    // acceptance is judged against every other stall source to avoid a loop.
    assign busy_stall = |(unit_busy & BLOCKING_MASK & ~hz.unit_ack);
    assign pre_stall  = busy_stall | ld_use_raw | sb_hazard | struct_hazard;
    assign acc_blk    = {NUM_UNITS{hz.exe_valid & ~pre_stall & ~flush_lsu}} & hz.exe_unit_req & BLOCKING_MASK;
    assign blk_stall  = |((unit_busy | acc_blk) & BLOCKING_MASK & ~hz.unit_ack);
    assign pipe_stall = blk_stall | pre_stall;
    assign ld_use     = ld_use_raw & ~blk_stall;

    assign redirect    = hz.exe_new_pc_req & ~pipe_stall;
    assign front_flush = redirect | flush_lsu;
    assign acc_nb      = {NUM_UNITS{hz.exe_valid & ~pipe_stall & ~front_flush}} & hz.exe_unit_req & ~BLOCKING_MASK;
    assign acc         = acc_blk | acc_nb;

    // One busy tracker per multi-cycle unit.
    for (genvar gi = 0; gi < int'(NUM_UNITS); gi++) begin : g_unit
        mc_unit_tracker u_trk (
            .clk     (clk),
            .rst_n   (rst_n),
            .acc_i   (acc[gi]),
            .ack_i   (hz.unit_ack[gi]),
            .flush_i (flush_lsu),
            .busy_o  (unit_busy[gi])
        );
    end

    // Scoreboard next state: retire clear first so a same-cycle set wins.
    always_comb begin
        sb_d = sb_q;
        if (hz.wrb_sb_clr & hz.wrb_rd_wr) sb_d[hz.wrb_rd_addr] = 1'b0;
        if ((|acc_nb) & hz.exe_rd_wr & (hz.exe_rd_addr != '0)) sb_d[hz.exe_rd_addr] = 1'b1;
        if (flush_lsu) sb_d = '0;
        sb_d[0] = 1'b0;
    end

    // Watchdog counts consecutive stalled cycles and latches a sticky timeout.
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (flush_lsu | ~pipe_stall) wdog_d = '0;
        else if (wdog_q != '1)       wdog_d = wdog_q + WDOG_W'(1);
        if (wdog_d == '1)            timeout_d = 1'b1;
    end

    // Registered scoreboard and watchdog state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q      <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            sb_q      <= sb_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign hz.fwd_lsu_rs1    = lsu_hit_rs1 & ~hz.lsu_late;
    assign hz.fwd_lsu_rs2    = lsu_hit_rs2 & ~hz.lsu_late;
    assign hz.fwd_wrb_rs1    = wrb_hit_rs1;
    assign hz.fwd_wrb_rs2    = wrb_hit_rs2;
    assign hz.pipe_stall     = pipe_stall;
    assign hz.exe2lsu_stall  = blk_stall;
    assign hz.if2id_flush    = front_flush;
    assign hz.id2exe_flush   = front_flush;
    assign hz.exe2lsu_flush  = ((ld_use | sb_hazard | struct_hazard) & ~blk_stall) | flush_lsu;
    assign hz.lsu_flush      = flush_lsu;
    assign hz.exe_new_pc_out = redirect & ~hz.csr_new_pc_req;
    assign hz.csr_new_pc_out = hz.csr_new_pc_req;
    assign hz.unit_busy      = unit_busy;
    assign hz.sb_busy        = sb_q;
    assign hz.stall_timeout  = timeout_q;

endmodule
